// File: rtl/arith_pkg.sv
`default_nettype none
//==============================================================================
// Package  : arith_pkg
// Brief    : Shared arithmetic definitions: add/sub opcode encoding and the
//            carry-slice width helper used by the pipelined adder.
// Revision : 1.0 - initial release
//==============================================================================
package arith_pkg;

    // Opcode shared with the ALU decoder.
    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } op_e;

    // Width of one carry slice. A zero stage count is clamped so the division
    // stays defined long enough for the top-level parameter check to report it.
    function automatic int slice_width(input int n, input int stages);
        return n / ((stages < 1) ? 1 : stages);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_slice.sv
`default_nettype none
//==============================================================================
// Module   : adder_slice
// Brief    : Combinational W-bit ripple-carry adder built from full_adder cells.
//            One slice resolves one pipeline stage's share of the carry chain.
// Revision : 1.0 - initial release
//==============================================================================
module adder_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (w_c[i]),
            .s  (s[i]),
            .co (w_c[i+1])
        );
    end

    assign co = w_c[W];

endmodule
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
//==============================================================================
// Module   : full_adder
// Brief    : One-bit full adder cell, the building block of the ripple slices.
// Revision : 1.0 - initial release
//==============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
//==============================================================================
// Module   : pipelined_addsub
// Brief    : N-bit adder/subtractor whose carry chain is cut into STAGES equal
//            slices, one slice per pipeline stage. Valid/ready on both sides,
//            a single global advance enable, registered sum/cout/ovf/zero.
// Revision : 1.0 - initial release
//==============================================================================
module pipelined_addsub
    import arith_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    localparam int c_w = slice_width(N, STAGES);

    if (STAGES < 1 || (N % STAGES) != 0) begin : g_bad_params
        $error("pipelined_addsub: STAGES must be >= 1 and divide N exactly");
    end

    op_e          w_op;
    logic [N-1:0] w_be;
    logic         w_c0;
    logic         w_en;

    logic [N-1:0] r_out_sum;
    logic         r_out_cout;
    logic         r_out_ovf;
    logic         r_out_zero;
    logic         r_out_vld;

    // Subtraction is a + ~b with the carry-in inverted into a borrow.
    assign w_op = op_e'(sub);
    assign w_be = (w_op == SUB) ? ~b : b;
    assign w_c0 = (w_op == SUB) ? ~cin : cin;

    // Whole pipe advances together unless a presented result is being held.
    assign w_en     = ~r_out_vld | out_ready;
    assign in_ready = w_en;

    assign out_valid = r_out_vld;
    assign sum       = r_out_sum;
    assign cout      = r_out_cout;
    assign ovf       = r_out_ovf;
    assign zero      = r_out_zero;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be added when this stage starts.
        localparam int c_rem = N - k * c_w;

        logic [c_rem-1:0]       w_a_in;
        logic [c_rem-1:0]       w_b_in;
        logic                   w_c_in;
        logic                   w_v_in;
        logic [c_w-1:0]         w_s;
        logic                   w_co;
        logic [(k+1)*c_w-1:0]   w_res;

        if (k == 0) begin : g_first
            assign w_a_in = a;
            assign w_b_in = w_be;
            assign w_c_in = w_c0;
            assign w_v_in = in_valid;
            assign w_res  = w_s;
        end else begin : g_next
            assign w_a_in = g_stage[k-1].g_mid.r_a;
            assign w_b_in = g_stage[k-1].g_mid.r_b;
            assign w_c_in = g_stage[k-1].g_mid.r_c;
            assign w_v_in = g_stage[k-1].g_mid.r_vld;
            assign w_res  = {w_s, g_stage[k-1].g_mid.r_sum};
        end

        adder_slice #(
            .W (c_w)
        ) u_slice (
            .a  (w_a_in[c_w-1:0]),
            .b  (w_b_in[c_w-1:0]),
            .ci (w_c_in),
            .s  (w_s),
            .co (w_co)
        );

        if (k < STAGES - 1) begin : g_mid
            logic [c_rem-c_w-1:0]  r_a;
            logic [c_rem-c_w-1:0]  r_b;
            logic [(k+1)*c_w-1:0]  r_sum;
            logic                  r_c;
            logic                  r_vld;

            // Register the resolved low bits, the slice carry and the skewed upper operands.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_sum <= '0;
                    r_c   <= 1'b0;
                    r_vld <= 1'b0;
                end else if (w_en) begin
                    r_a   <= w_a_in[c_rem-1:c_w];
                    r_b   <= w_b_in[c_rem-1:c_w];
                    r_sum <= w_res;
                    r_c   <= w_co;
                    r_vld <= w_v_in;
                end
            end
        end else begin : g_last
            logic w_ovf;

            // Top slice still holds the operand sign bits needed for signed overflow.
            assign w_ovf = (w_a_in[c_w-1] == w_b_in[c_w-1]) && (w_res[N-1] != w_a_in[c_w-1]);

            // Final stage registers the complete result and its flags.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_out_sum  <= '0;
                    r_out_cout <= 1'b0;
                    r_out_ovf  <= 1'b0;
                    r_out_zero <= 1'b0;
                    r_out_vld  <= 1'b0;
                end else if (w_en) begin
                    r_out_sum  <= w_res;
                    r_out_cout <= w_co;
                    r_out_ovf  <= w_ovf;
                    r_out_zero <= ~|w_res;
                    r_out_vld  <= w_v_in;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
//==============================================================================
// Module   : tb_pipelined_addsub
// Brief    : Scoreboard bench for pipelined_addsub. Three instances
//            (32/4, 8/1, 64/8) share one stimulus stream; the 32/4 instance
//            additionally sees back-pressure and a mid-stream reset.
// Revision : 1.0 - initial release
//==============================================================================
module tb_pipelined_addsub;

    localparam int N0 = 32;
    localparam int S0 = 4;
    localparam int N1 = 8;
    localparam int S1 = 1;
    localparam int N2 = 64;
    localparam int S2 = 8;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        sec_en;
    logic        in_valid_s;
    logic [63:0] a_r;
    logic [63:0] b_r;
    logic        sub_r;
    logic        cin_r;

    logic          rdy, ov, co, of, zr;
    logic [N0-1:0] sm;
    logic          rdy8, ov8, co8, of8, zr8;
    logic [N1-1:0] sm8;
    logic          rdy64, ov64, co64, of64, zr64;
    logic [N2-1:0] sm64;

    exp_t q32[$];
    exp_t q8[$];
    exp_t q64[$];

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    logic prev_stall = 1'b0;
    logic [N0-1:0] prev_sum = '0;

    assign in_valid_s = in_valid & sec_en;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pipelined_addsub #(.N(N0), .STAGES(S0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy),
        .a(a_r[N0-1:0]), .b(b_r[N0-1:0]), .sub(sub_r), .cin(cin_r),
        .out_valid(ov), .out_ready(out_ready),
        .sum(sm), .cout(co), .ovf(of), .zero(zr)
    );

    pipelined_addsub #(.N(N1), .STAGES(S1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(rdy8),
        .a(a_r[N1-1:0]), .b(b_r[N1-1:0]), .sub(sub_r), .cin(cin_r),
        .out_valid(ov8), .out_ready(1'b1),
        .sum(sm8), .cout(co8), .ovf(of8), .zero(zr8)
    );

    pipelined_addsub #(.N(N2), .STAGES(S2)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(rdy64),
        .a(a_r), .b(b_r), .sub(sub_r), .cin(cin_r),
        .out_valid(ov64), .out_ready(1'b1),
        .sum(sm64), .cout(co64), .ovf(of64), .zero(zr64)
    );

    // Reference: plain integer arithmetic on n-bit operands, unsigned for
    // sum/cout and signed range checking for overflow.
    function automatic exp_t ref_op(input int n, input logic [63:0] ia, input logic [63:0] ib,
                                    input logic s, input logic c);
        exp_t              e;
        logic [65:0]       m, ua, ub, ur, top;
        logic signed [66:0] sa, sb, sc, sr, hi, lo;
        top = 66'd1 << n;
        m   = top - 66'd1;
        ua  = {2'b00, ia} & m;
        ub  = {2'b00, ib} & m;
        if (!s) begin
            ur     = ua + ub + 66'(c);
            e.cout = (ur >= top);
        end else begin
            e.cout = (ua >= ub + 66'(c));
            ur     = ua - ub - 66'(c);
        end
        ur     = ur & m;
        e.sum  = ur[63:0];
        e.zero = (ur == 66'd0);
        sa = $signed({1'b0, ua});
        sb = $signed({1'b0, ub});
        if (ua[n-1]) sa = sa - $signed({1'b0, top});
        if (ub[n-1]) sb = sb - $signed({1'b0, top});
        sc = $signed({66'd0, c});
        sr = s ? (sa - sb - sc) : (sa + sb + sc);
        hi = $signed({1'b0, (66'd1 << (n - 1)) - 66'd1});
        lo = -$signed({1'b0, 66'd1 << (n - 1)});
        e.ovf = (sr > hi) || (sr < lo);
        e.lat = 1'b0;
        e.acc = 0;
        return e;
    endfunction

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic check_out(input string nm, input exp_t e, input logic [63:0] s_act,
                             input logic c_act, input logic o_act, input logic z_act, input int stg);
        cmp({nm, " sum"},  s_act, e.sum);
        cmp({nm, " cout"}, 64'(c_act), 64'(e.cout));
        cmp({nm, " ovf"},  64'(o_act), 64'(e.ovf));
        cmp({nm, " zero"}, 64'(z_act), 64'(e.zero));
        if (e.lat) cmp({nm, " latency"}, 64'(cyc - e.acc), 64'(stg - 1));
    endtask

    // Issue one operation; called at a falling edge, returns at the falling
    // edge after it was accepted.
    task automatic send(input logic [63:0] ta, input logic [63:0] tbv,
                        input logic ts, input logic tc, input logic lat);
        exp_t e;
        logic ok;
        a_r = ta; b_r = tbv; sub_r = ts; cin_r = tc;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int w = 0; w < 200; w++) begin
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL send in_ready: actual=0 required=1 within 200 cycles");
        end else begin
            e = ref_op(N0, ta, tbv, ts, tc); e.lat = lat; e.acc = cyc + 1; q32.push_back(e);
            if (sec_en) begin
                cmp("secondary in_ready", 64'({rdy8, rdy64}), 64'd3);
                e = ref_op(N1, ta, tbv, ts, tc); e.lat = lat; e.acc = cyc + 1; q8.push_back(e);
                e = ref_op(N2, ta, tbv, ts, tc); e.lat = lat; e.acc = cyc + 1; q64.push_back(e);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (q32.size() == 0 && q8.size() == 0 && q64.size() == 0) break;
            @(negedge clk); #3;
        end
        cmp("drain dut32 queue", 64'(q32.size()), 64'd0);
        cmp("drain dut8 queue",  64'(q8.size()),  64'd0);
        cmp("drain dut64 queue", 64'(q64.size()), 64'd0);
        @(negedge clk);
    endtask

    // Main-instance monitor: scoreboard pop on output transfer, plus stall checks.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (ov && out_ready) begin
                if (q32.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL dut32 unexpected output: actual=%h required=none", sm);
                end else begin
                    e = q32.pop_front();
                    check_out("dut32", e, 64'(sm), co, of, zr, S0);
                end
            end
            if (ov && !out_ready) begin
                cmp("stall in_ready", 64'(rdy), 64'd0);
                if (prev_stall) cmp("stall sum stable", 64'(sm), 64'(prev_sum));
                prev_stall = 1'b1;
                prev_sum   = sm;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // 8-bit single-stage instance monitor.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n && ov8) begin
            if (q8.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL dut8 unexpected output: actual=%h required=none", sm8);
            end else begin
                e = q8.pop_front();
                check_out("dut8", e, 64'(sm8), co8, of8, zr8, S1);
            end
        end
    end

    // 64-bit eight-stage instance monitor.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n && ov64) begin
            if (q64.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL dut64 unexpected output: actual=%h required=none", sm64);
            end else begin
                e = q64.pop_front();
                check_out("dut64", e, sm64, co64, of64, zr64, S2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sec_en = 1'b0;
        a_r = '0; b_r = '0; sub_r = 1'b0; cin_r = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        cmp("reset out_valid", 64'({ov, ov8, ov64}), 64'd0);
        cmp("reset in_ready",  64'(rdy), 64'd1);
        cmp("reset sum",       64'(sm), 64'd0);
        cmp("reset flags",     64'({co, of, zr}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed boundaries and a random stream on all three widths.
        sec_en = 1'b1;
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1);
        send(64'h0000_0000_7FFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1);
        send(64'h0000_0000_0000_007F, 64'd1, 1'b0, 1'b0, 1'b1);
        send(64'd5, 64'd7, 1'b1, 1'b0, 1'b1);
        send(64'd0, 64'd0, 1'b1, 1'b1, 1'b1);
        send(64'h8000_0000_8000_0080, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'b1);
        end
        drain();
        sec_en = 1'b0;

        // Back-pressure in the middle of a stream on the main instance.
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    send({32'd0, $urandom}, {32'd0, $urandom}, 1'($urandom), 1'($urandom), 1'b0);
                end
            end
            begin
                repeat (6) @(negedge clk);
                out_ready = 1'b0;
                repeat (6) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset with operations in flight.
        send(64'd11, 64'd22, 1'b0, 1'b0, 1'b1);
        send(64'd33, 64'd44, 1'b0, 1'b1, 1'b1);
        send(64'd55, 64'd66, 1'b1, 1'b0, 1'b1);
        a_r = 64'd77; b_r = 64'd88; sub_r = 1'b0; cin_r = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        cmp("pre-reset out_valid", 64'(ov), 64'd1);
        rst_n = 1'b0;
        #1;
        cmp("async reset out_valid", 64'(ov), 64'd0);
        cmp("async reset sum",       64'(sm), 64'd0);
        cmp("async reset flags",     64'({co, of, zr}), 64'd0);
        cmp("async reset in_ready",  64'(rdy), 64'd1);
        q32.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(64'hDEAD_BEEF, 64'h2152_4111, 1'b0, 1'b0, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
